// File: rtl/dram_pkg.sv
// Shared types and default timing for the DRAM bank responder slice.
package dram_pkg;

   typedef enum logic [1:0] {
      CMD_NOP = 2'b00,
      CMD_ACT = 2'b01,
      CMD_RD  = 2'b10,
      CMD_WR  = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      BANK_IDLE    = 2'b00,
      BANK_PRECHG  = 2'b01,
      BANK_ACTVING = 2'b10,
      BANK_ACTIVE  = 2'b11
   } bank_state_e;

   localparam int DEFAULT_T_RCD = 2;
   localparam int DEFAULT_T_RP  = 2;
   localparam int DEFAULT_T_CL  = 3;

endpackage

// File: rtl/dram_bank_fsm.sv
// One bank's state machine: open-row register plus the precharge/activate timer.
module dram_bank_fsm
   import dram_pkg::*;
#(
   parameter int ROWS  = 128,
   parameter int T_RCD = DEFAULT_T_RCD,
   parameter int T_RP  = DEFAULT_T_RP
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    act,
   input  logic [$clog2(ROWS)-1:0] row,
   output bank_state_e             state,
   output logic [$clog2(ROWS)-1:0] open_row
);

   localparam int AW   = $clog2(ROWS);
   localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int TW   = $clog2(TMAX + 1);

   logic [TW-1:0] timer;

   // From IDLE the command cycle itself counts toward tRCD, so ACTVING is
   // loaded one short; after a precharge the full tRCD is spent in ACTVING.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state    <= BANK_IDLE;
         open_row <= '0;
         timer    <= '0;
      end else begin
         case (state)
            BANK_IDLE: begin
               if (act) begin
                  open_row <= row;
                  if (T_RCD == 1) begin
                     state <= BANK_ACTIVE;
                  end else begin
                     state <= BANK_ACTVING;
                     timer <= TW'(T_RCD - 1);
                  end
               end
            end
            BANK_ACTIVE: begin
               if (act && (row != open_row)) begin
                  open_row <= row;
                  state    <= BANK_PRECHG;
                  timer    <= TW'(T_RP);
               end
            end
            BANK_PRECHG: begin
               if (timer <= TW'(1)) begin
                  state <= BANK_ACTVING;
                  timer <= TW'(T_RCD);
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            BANK_ACTVING: begin
               if (timer <= TW'(1)) begin
                  state <= BANK_ACTIVE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: state <= BANK_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dram_bank_resp.sv
// Multi-bank DRAM responder: per-bank FSMs, memory array and a fixed-latency read pipeline.
module dram_bank_resp
   import dram_pkg::*;
#(
   parameter int NUMBER_OF_BANKS = 8,
   parameter int ROWS            = 128,
   parameter int COLS            = 8,
   parameter int DATA_WIDTH      = 1,
   parameter int T_RCD           = DEFAULT_T_RCD,
   parameter int T_RP            = DEFAULT_T_RP,
   parameter int T_CL            = DEFAULT_T_CL
) (
   input  logic                               clk,
   input  logic                               rst_b,
   input  logic [1:0]                         cmd,
   input  logic [$clog2(NUMBER_OF_BANKS)-1:0] cs,
   input  logic [$clog2(ROWS)-1:0]            addr,
   input  logic [DATA_WIDTH-1:0]              wr_data,
   output logic [DATA_WIDTH-1:0]              dram_data_out,
   output logic                               rd_valid,
   output logic [NUMBER_OF_BANKS-1:0]         bank_ready,
   output logic                               cmd_err
);

   localparam int CSW = $clog2(NUMBER_OF_BANKS);
   localparam int AW  = $clog2(ROWS);
   localparam int CW  = $clog2(COLS);

   cmd_e            cmd_dec;
   bank_state_e     bank_state [NUMBER_OF_BANKS];
   logic [AW-1:0]   open_row   [NUMBER_OF_BANKS];
   bank_state_e     target_state;
   logic [CW-1:0]   col;
   logic            rd_ok;
   logic            wr_ok;
   logic            cmd_illegal;
   logic            cmd_err_q;

   logic [DATA_WIDTH-1:0] mem [NUMBER_OF_BANKS][ROWS][COLS];

   logic [T_CL-1:0]       pipe_valid;
   logic [DATA_WIDTH-1:0] pipe_data [T_CL];

   assign cmd_dec = cmd_e'(cmd);
   assign col     = addr[CW-1:0];

   for (genvar g = 0; g < NUMBER_OF_BANKS; g++) begin : g_bank
      dram_bank_fsm #(
         .ROWS  (ROWS),
         .T_RCD (T_RCD),
         .T_RP  (T_RP)
      ) u_bank_fsm (
         .clk      (clk),
         .rst_b    (rst_b),
         .act      ((cmd_dec == CMD_ACT) && (cs == CSW'(g))),
         .row      (addr),
         .state    (bank_state[g]),
         .open_row (open_row[g])
      );

      assign bank_ready[g] = rst_b && (bank_state[g] == BANK_ACTIVE);
   end

   // ACT is only refused mid-transition; RD/WR need the target bank open.
   always_comb begin
      target_state = bank_state[cs];
      rd_ok        = (cmd_dec == CMD_RD) && (target_state == BANK_ACTIVE);
      wr_ok        = (cmd_dec == CMD_WR) && (target_state == BANK_ACTIVE);
      cmd_illegal  = ((cmd_dec == CMD_ACT) &&
                      ((target_state == BANK_PRECHG) || (target_state == BANK_ACTVING))) ||
                     (((cmd_dec == CMD_RD) || (cmd_dec == CMD_WR)) &&
                      (target_state != BANK_ACTIVE));
   end

   // The array is deliberately not reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (rst_b && wr_ok) begin
         mem[cs][open_row[cs]][col] <= wr_data;
      end
   end

   // Data is captured at issue, so a later precharge cannot disturb it.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         pipe_valid <= '0;
         for (int i = 0; i < T_CL; i++) begin
            pipe_data[i] <= '0;
         end
         cmd_err_q <= 1'b0;
      end else begin
         pipe_valid[0] <= rd_ok;
         pipe_data[0]  <= rd_ok ? mem[cs][open_row[cs]][col] : '0;
         for (int i = 1; i < T_CL; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
         cmd_err_q <= cmd_illegal;
      end
   end

   assign rd_valid      = rst_b && pipe_valid[T_CL-1];
   assign dram_data_out = rd_valid ? pipe_data[T_CL-1] : '0;
   assign cmd_err       = rst_b && cmd_err_q;

endmodule

// File: tb/tb_dram_bank_resp.sv
// Directed, table-driven check of the DRAM bank responder with default parameters.
module tb_dram_bank_resp;
   import dram_pkg::*;

   typedef struct {
      logic       rst_b;
      cmd_e       cmd;
      logic [2:0] cs;
      logic [6:0] addr;
      logic       wd;
      logic       exp_valid;
      logic       exp_data;
      logic       chk_data;
      logic [7:0] exp_ready;
      logic       exp_err;
   } vec_t;

   logic       clk;
   logic       rst_b;
   logic [1:0] cmd;
   logic [2:0] cs;
   logic [6:0] addr;
   logic [0:0] wr_data;
   logic [0:0] dram_data_out;
   logic       rd_valid;
   logic [7:0] bank_ready;
   logic       cmd_err;

   int checks;
   int failures;
   int vec_idx;
   vec_t vecs[$];

   dram_bank_resp u_dut (
      .clk           (clk),
      .rst_b         (rst_b),
      .cmd           (cmd),
      .cs            (cs),
      .addr          (addr),
      .wr_data       (wr_data),
      .dram_data_out (dram_data_out),
      .rd_valid      (rd_valid),
      .bank_ready    (bank_ready),
      .cmd_err       (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, cmd_e c, int b, int a, logic d, logic ev,
                               logic ed, logic cd, logic [7:0] er, logic ee);
      vec_t v;
      v.rst_b     = r;
      v.cmd       = c;
      v.cs        = 3'(b);
      v.addr      = 7'(a);
      v.wd        = d;
      v.exp_valid = ev;
      v.exp_data  = ed;
      v.chk_data  = cd;
      v.exp_ready = er;
      v.exp_err   = ee;
      return v;
   endfunction

   task automatic check_bit(string name, logic got, logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL vec %0d %s: got %0b expected %0b", vec_idx, name, got, want);
      end
   endtask

   // Drives one cycle's inputs, checks that cycle's outputs, then advances a clock.
   task automatic apply_stimulus(vec_t v);
      rst_b   = v.rst_b;
      cmd     = v.cmd;
      cs      = v.cs;
      addr    = v.addr;
      wr_data = v.wd;
      #1;
      check_output(v);
      @(posedge clk);
      #1;
      vec_idx++;
   endtask

   task automatic check_output(vec_t v);
      check_bit("rd_valid", rd_valid, v.exp_valid);
      check_bit("cmd_err", cmd_err, v.exp_err);
      checks++;
      if (bank_ready !== v.exp_ready) begin
         failures++;
         $display("[TB] FAIL vec %0d bank_ready: got %h expected %h", vec_idx, bank_ready, v.exp_ready);
      end
      if (!v.exp_valid || v.chk_data) begin
         check_bit("dram_data_out", dram_data_out[0], v.exp_valid ? v.exp_data : 1'b0);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      vec_idx  = 0;
      rst_b    = 1'b0;
      cmd      = 2'b00;
      cs       = '0;
      addr     = '0;
      wr_data  = '0;

      // reset, open bank 2 row 5, first read, write/read-back, illegal RD
      vecs.push_back(mk(0, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(0, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(1, CMD_ACT, 2, 5, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(1, CMD_RD,  2, 0, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_WR,  2, 3, 1, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_RD,  2, 3, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 1, 0, 0, 8'h04, 0));
      vecs.push_back(mk(1, CMD_RD,  4, 0, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 1, 1, 1, 8'h04, 1));
      // back-to-back reads of cols 1,2,3,1 holding 1,0,1,1
      vecs.push_back(mk(1, CMD_WR,  2, 1, 1, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_WR,  2, 2, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_RD,  2, 1, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_RD,  2, 2, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_RD,  2, 3, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_RD,  2, 1, 0, 1, 1, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 1, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 1, 1, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 1, 1, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h04, 0));
      // row change 5 -> 9, ACT during PRECHG is refused
      vecs.push_back(mk(1, CMD_ACT, 2, 9, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_ACT, 2, 9, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 1));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(1, CMD_WR,  2, 3, 0, 0, 0, 1, 8'h04, 0));
      // reopen row 5 while bank 4 activates independently
      vecs.push_back(mk(1, CMD_ACT, 2, 5, 0, 0, 0, 1, 8'h04, 0));
      vecs.push_back(mk(1, CMD_ACT, 4, 1, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h10, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h10, 0));
      vecs.push_back(mk(1, CMD_RD,  2, 3, 0, 0, 0, 1, 8'h14, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h14, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h14, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 1, 1, 1, 8'h14, 0));
      vecs.push_back(mk(1, CMD_ACT, 2, 5, 0, 0, 0, 1, 8'h14, 0));
      vecs.push_back(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h14, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
      end

      // reset one cycle after a RD flushes it; memory survives re-ACT
      apply_stimulus(mk(1, CMD_RD,  2, 3, 0, 0, 0, 1, 8'h14, 0));
      apply_stimulus(mk(0, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      apply_stimulus(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      apply_stimulus(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      apply_stimulus(mk(1, CMD_ACT, 2, 5, 0, 0, 0, 1, 8'h00, 0));
      apply_stimulus(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h00, 0));
      apply_stimulus(mk(1, CMD_RD,  2, 3, 0, 0, 0, 1, 8'h04, 0));
      apply_stimulus(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h04, 0));
      apply_stimulus(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h04, 0));
      apply_stimulus(mk(1, CMD_NOP, 0, 0, 0, 1, 1, 1, 8'h04, 0));
      apply_stimulus(mk(1, CMD_NOP, 0, 0, 0, 0, 0, 1, 8'h04, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
